// File: rtl/condition_flag_unit.sv
// NZCV flag register plus a one-entry condition-check result buffer; condPass appears one cycle after accept.
// Backpressure: condReady drops only while a result is held and resultReady is low; same-cycle flag updates forward into the check.
module condition_flag_unit (
  input  logic       clk,
  input  logic       resetN,
  input  logic       aluN,
  input  logic       aluZ,
  input  logic       aluC,
  input  logic       aluV,
  input  logic [3:0] aluOpCode,
  input  logic       flagWrite,
  input  logic       shifterCarry,
  output logic [3:0] flags,
  output logic       carryOut,
  input  logic       condValid,
  input  logic [3:0] cond,
  output logic       condReady,
  output logic       condPassValid,
  output logic       condPass,
  input  logic       resultReady
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       pass_nxt;
  logic       is_cmp, is_arith, flag_upd, accept;
  logic [3:0] flags_nxt;

  // flags layout is {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = !z;
      4'b0010: cond_eval = cy;
      4'b0011: cond_eval = !cy;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = !n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = !v;
      4'b1000: cond_eval = cy & !z;
      4'b1001: cond_eval = !cy | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = !z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // TST/TEQ/CMP/CMN update flags regardless of the S-bit
  always_comb begin
    is_cmp    = (aluOpCode[3:2] == 2'b10);
    is_arith  = (aluOpCode inside {[4'd2:4'd7], 4'd10, 4'd11});
    flag_upd  = flagWrite | is_cmp;
    flags_nxt = flags;
    if (flag_upd) begin
      flags_nxt[3] = aluN;
      flags_nxt[2] = aluZ;
      flags_nxt[1] = is_arith ? aluC : shifterCarry;
      flags_nxt[0] = is_arith ? aluV : flags[0];
    end
  end

  always_comb begin
    state_nxt     = state;
    pass_nxt      = condPass;
    condPassValid = (state == FULL);
    condReady     = (state == EMPTY) | resultReady;
    accept        = condValid & condReady;
    if (accept) begin
      state_nxt = FULL;
      pass_nxt  = cond_eval(cond, flags_nxt);
    end else if ((state == FULL) && resultReady) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= EMPTY;
      condPass <= 1'b0;
      flags    <= 4'b0000;
    end else begin
      state    <= state_nxt;
      condPass <= pass_nxt;
      flags    <= flags_nxt;
    end
  end

  assign carryOut = flags[1];

endmodule

// File: tb/tb_condition_flag_unit.sv
// Directed bench for condition_flag_unit: reset, flag update classes, forwarding, backpressure, full cond sweep.
module tb_condition_flag_unit;

  logic       clk = 1'b0;
  logic       resetN;
  logic       aluN, aluZ, aluC, aluV;
  logic [3:0] aluOpCode;
  logic       flagWrite, shifterCarry;
  logic [3:0] flags;
  logic       carryOut;
  logic       condValid;
  logic [3:0] cond;
  logic       condReady, condPassValid, condPass;
  logic       resultReady;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_CMP = 4'b1010;

  condition_flag_unit dut (
    .clk(clk), .resetN(resetN),
    .aluN(aluN), .aluZ(aluZ), .aluC(aluC), .aluV(aluV),
    .aluOpCode(aluOpCode), .flagWrite(flagWrite), .shifterCarry(shifterCarry),
    .flags(flags), .carryOut(carryOut),
    .condValid(condValid), .cond(cond), .condReady(condReady),
    .condPassValid(condPassValid), .condPass(condPass), .resultReady(resultReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic [3:0] op, input logic fw, input logic [3:0] nzcv, input logic sc);
    aluOpCode = op;
    flagWrite = fw;
    {aluN, aluZ, aluC, aluV} = nzcv;
    shifterCarry = sc;
  endtask

  // Reference condition table, f = {N,Z,C,V}
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return cy;
      4'd3:  return ~cy;
      4'd4:  return n;
      4'd5:  return ~n;
      4'd6:  return v;
      4'd7:  return ~v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n ~^ v;
      4'd11: return n ^ v;
      4'd12: return !z && (n ~^ v);
      4'd13: return z || (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    resetN = 1'b0;
    set_alu(4'b0000, 1'b0, 4'b0000, 1'b0);
    condValid = 1'b0; cond = 4'b0000; resultReady = 1'b0;
    #3;
    chk("rst_flags", flags, 4'b0000);
    chk("rst_carry", {3'b0, carryOut}, 4'd0);
    chk("rst_pv", {3'b0, condPassValid}, 4'd0);
    chk("rst_pass", {3'b0, condPass}, 4'd0);
    chk("rst_ready", {3'b0, condReady}, 4'd1);
    @(negedge clk); @(negedge clk);
    chk("rst_flags_held", flags, 4'b0000);
    resetN = 1'b1;

    // ADD with S-bit, then CS check on registered flags
    set_alu(OP_ADD, 1'b1, 4'b0011, 1'b0);
    @(negedge clk);
    chk("add_flags", flags, 4'b0011);
    chk("add_carry", {3'b0, carryOut}, 4'd1);
    set_alu(OP_ADD, 1'b0, 4'b1100, 1'b0);
    condValid = 1'b1; cond = 4'b0010;
    @(negedge clk);
    chk("cs_pv", {3'b0, condPassValid}, 4'd1);
    chk("cs_pass", {3'b0, condPass}, 4'd1);
    chk("noupd_flags", flags, 4'b0011);

    // ORR with S-bit: C from shifter, V held; buffer drains this edge
    condValid = 1'b0; resultReady = 1'b1;
    set_alu(OP_ORR, 1'b1, 4'b1010, 1'b0);
    @(negedge clk);
    chk("orr_flags", flags, 4'b1001);
    chk("drain_pv", {3'b0, condPassValid}, 4'd0);

    // CMP without S-bit still updates; EQ sees forwarded Z
    set_alu(OP_CMP, 1'b0, 4'b0110, 1'b1);
    condValid = 1'b1; cond = 4'b0000;
    @(negedge clk);
    chk("cmp_flags", flags, 4'b0110);
    chk("cmp_eq_pv", {3'b0, condPassValid}, 4'd1);
    chk("cmp_eq_pass", {3'b0, condPass}, 4'd1);

    // GT accepted while consuming, with forwarded flags 0000 -> pass
    set_alu(OP_ADD, 1'b1, 4'b0000, 1'b0);
    cond = 4'b1100;
    @(negedge clk);
    chk("gt_flags", flags, 4'b0000);
    chk("gt_pass", {3'b0, condPass}, 4'd1);

    // Hold under backpressure; offered NV must be ignored
    set_alu(OP_ADD, 1'b0, 4'b0000, 1'b0);
    resultReady = 1'b0; cond = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {3'b0, condReady}, 4'd0);
      @(negedge clk);
      chk("bp_pv", {3'b0, condPassValid}, 4'd1);
      chk("bp_pass", {3'b0, condPass}, 4'd1);
    end
    resultReady = 1'b1;
    #1;
    chk("b2b_ready", {3'b0, condReady}, 4'd1);
    @(negedge clk);
    chk("nv_pv", {3'b0, condPassValid}, 4'd1);
    chk("nv_pass", {3'b0, condPass}, 4'd0);
    condValid = 1'b0;
    @(negedge clk);
    chk("empty_pv", {3'b0, condPassValid}, 4'd0);

    // Full sweep: load each flag value, then back-to-back checks of all 16 conds
    for (int f = 0; f < 16; f++) begin
      set_alu(OP_ADD, 1'b1, f[3:0], 1'b0);
      condValid = 1'b0;
      @(negedge clk);
      chk("sweep_flags", flags, f[3:0]);
      set_alu(OP_ADD, 1'b0, ~f[3:0], 1'b0);
      for (int c = 0; c < 16; c++) begin
        condValid = 1'b1; cond = c[3:0];
        @(negedge clk);
        chk($sformatf("sweep_f%0d_c%0d", f, c), {3'b0, condPass}, {3'b0, ref_cond(c[3:0], f[3:0])});
      end
    end
    condValid = 1'b0;
    @(negedge clk);

    // Async reset while FULL with flags 1111
    set_alu(OP_ADD, 1'b1, 4'b1111, 1'b0);
    condValid = 1'b1; cond = 4'b1110;
    @(negedge clk);
    chk("pre_rst_flags", flags, 4'b1111);
    chk("pre_rst_pv", {3'b0, condPassValid}, 4'd1);
    condValid = 1'b0; resultReady = 1'b0;
    set_alu(OP_ADD, 1'b1, 4'b0101, 1'b0);
    #2 resetN = 1'b0;
    #1;
    chk("arst_flags", flags, 4'b0000);
    chk("arst_carry", {3'b0, carryOut}, 4'd0);
    chk("arst_pv", {3'b0, condPassValid}, 4'd0);
    chk("arst_pass", {3'b0, condPass}, 4'd0);
    chk("arst_ready", {3'b0, condReady}, 4'd1);
    @(negedge clk);
    chk("arst_upd_discard", flags, 4'b0000);
    set_alu(OP_ADD, 1'b0, 4'b0000, 1'b0);
    resetN = 1'b1;
    condValid = 1'b1; cond = 4'b0001;
    @(negedge clk);
    chk("post_rst_pv", {3'b0, condPassValid}, 4'd1);
    chk("post_rst_ne", {3'b0, condPass}, 4'd1);
    condValid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
